// File: rtl/fetch_buf.sv
// fetch_buf: instruction fetch address generator plus a small {pc, inst} queue
// that feeds the decode stage.
//
// Optional feature: define FETCH_BUF_BYPASS_EN to let a word that is fetched
// into an empty queue appear at the outputs in the same cycle. If the decode
// stage takes it in that cycle, the word never occupies a queue slot. In the
// default build the out_* outputs are driven only from queue registers.
module fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_addr,
    output logic                     imem_req,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_data,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_buf: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // Sequential fetch advances one 32-bit word; wraps silently at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are forced to word alignment.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

    logic [31:0]       fetch_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  occ;

    // Queue storage holds data only, so it carries no reset; the pointers and
    // occupancy decide what is valid.
    logic [31:0]       q_pc   [DEPTH];
    logic [DATA_W-1:0] q_inst [DEPTH];

    logic              q_nonempty;
    logic              q_pop;
    logic              push;
    logic              wr_en;

    assign imem_addr = fetch_pc;
    assign count     = occ;

    // Request/push/pop qualification. A pop out of a full queue frees the slot
    // that the same-cycle fetch fills, so the request may stay up at full.
    always_comb begin
        q_nonempty = (occ != '0);
        q_pop      = q_nonempty && out_ready && !redirect;
        imem_req   = rst && !redirect && ((occ != FULL) || q_pop);
        push       = imem_req && imem_ack;
    end

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass;

    // Head selection with the empty-queue bypass; a bypassed word that the
    // decode stage accepts this cycle is not written into the queue.
    always_comb begin
        bypass    = push && !q_nonempty;
        wr_en     = push && !(bypass && out_ready);
        out_valid = q_nonempty || bypass;
        out_inst  = '0;
        out_pc    = '0;
        if (q_nonempty) begin
            out_inst = q_inst[rd_ptr];
            out_pc   = q_pc[rd_ptr];
        end else if (bypass) begin
            out_inst = imem_data;
            out_pc   = fetch_pc;
        end
    end
`else
    // Head selection from the queue registers only; outputs are zero when empty.
    always_comb begin
        wr_en     = push;
        out_valid = q_nonempty;
        out_inst  = '0;
        out_pc    = '0;
        if (q_nonempty) begin
            out_inst = q_inst[rd_ptr];
            out_pc   = q_pc[rd_ptr];
        end
    end
`endif

    // Control state: fetch address, pointers and occupancy. Redirect flushes
    // the queue and overrides any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else if (redirect) begin
            fetch_pc <= align_pc(redirect_pc);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (push) begin
                fetch_pc <= next_pc(fetch_pc);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, q_pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Queue write port: captures the fetched word with the address it came from.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_inst[wr_ptr] <= imem_data;
        end
    end

endmodule
